// File: rtl/mc_control_fsm.sv
// mc_control_fsm: main control unit of the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback, drives the datapath
// selects and write enables, and resolves branches from the ALU Zero flag.
// An optional memory-wait watchdog (WAIT_LIMIT > 0) sets a sticky
// MemTimeout and diverts the FSM to ILLEGAL.
// Build option MC_ILLEGAL_TRAP_EN: ILLEGAL becomes a terminal halt state and
// the Illegal output is added; otherwise ILLEGAL is a one-cycle NOP.
module mc_control_fsm #(
    parameter int WAIT_LIMIT = 0,
    parameter int WAIT_W     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic       Illegal,
`endif
    output logic       MemTimeout
);

    // ALU operation codes shared with the ALU decoder
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // RV32I major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [WAIT_W-1:0] LIMIT_M1 = WAIT_W'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALRADR,
        S_LUI,
        S_AUIPC,
        S_ILLEGAL
    } state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, cnt_next;
    logic              timeout_q;
    logic              wait_state, timeout;
    logic              pcwrite_c, memwrite_c, irwrite_c, regwrite_c;

    // Shared register/immediate ALU table; funct3 = 000 only subtracts for R-type
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic reg_form);
        logic [3:0] r;
        case (f3)
            3'b000:  r = (reg_form && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= cnt_next;
            if (timeout) timeout_q <= 1'b1;
        end
    end

    // Immediate format depends only on the opcode
    always_comb begin
        case (op)
            OP_LOAD, OP_OPIMM, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:                   ImmSrc = 3'b001;
            OP_BRANCH:                  ImmSrc = 3'b010;
            OP_LUI, OP_AUIPC:           ImmSrc = 3'b011;
            OP_JAL:                     ImmSrc = 3'b100;
            default:                    ImmSrc = 3'b000;
        endcase
    end

    // Next state, datapath selects and raw enables
    always_comb begin
        next_state = state;
        pcwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;

        wait_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
        timeout    = (WAIT_LIMIT > 0) && wait_state && !MemReady && (wait_cnt == LIMIT_M1);

        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irwrite_c = MemReady;
                pcwrite_c = MemReady;
                if (MemReady) next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_OPIMM:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALRADR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    default:           next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_c = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_c = 1'b1;
                if (MemReady) next_state = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7b5, 1'b1);
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct3, funct7b5, 1'b0);
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                next_state = S_FETCH;
                case (funct3)
                    3'b000: begin ALUControl = ALU_SUB;  pcwrite_c = Zero;  end
                    3'b001: begin ALUControl = ALU_SUB;  pcwrite_c = !Zero; end
                    3'b100: begin ALUControl = ALU_SLT;  pcwrite_c = !Zero; end
                    3'b101: begin ALUControl = ALU_SLT;  pcwrite_c = Zero;  end
                    3'b110: begin ALUControl = ALU_SLTU; pcwrite_c = !Zero; end
                    3'b111: begin ALUControl = ALU_SLTU; pcwrite_c = Zero;  end
                    default: next_state = S_ILLEGAL;
                endcase
            end
            S_JALRADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = S_JAL;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pcwrite_c  = 1'b1;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                next_state = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                next_state = S_ALUWB;
            end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                next_state = S_ILLEGAL;
`else
                next_state = S_FETCH;
`endif
            end
        endcase

        // An expired wait suppresses every enable in that same cycle
        if (timeout) begin
            next_state = S_ILLEGAL;
            pcwrite_c  = 1'b0;
            memwrite_c = 1'b0;
            irwrite_c  = 1'b0;
            regwrite_c = 1'b0;
        end

        // Counting only while parked in a wait state also clears it on every entry
        cnt_next = '0;
        if ((WAIT_LIMIT > 0) && wait_state && !MemReady && (next_state == state))
            cnt_next = wait_cnt + 1'b1;
    end

    // Enables are forced off while reset is asserted
    always_comb begin
        PCWrite    = pcwrite_c  & reset_n;
        MemWrite   = memwrite_c & reset_n;
        IRWrite    = irwrite_c  & reset_n;
        RegWrite   = regwrite_c & reset_n;
        MemTimeout = timeout_q  & reset_n;
    end

`ifdef MC_ILLEGAL_TRAP_EN
    assign Illegal = (state == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed and randomized check of mc_control_fsm against an
// instruction-level reference that walks each instruction's expected cycles.
module tb_mc_control_fsm;

    localparam int LIMIT = 5;

    localparam logic [3:0] A_ADD  = 4'b0000;
    localparam logic [3:0] A_SUB  = 4'b0001;
    localparam logic [3:0] A_AND  = 4'b0010;
    localparam logic [3:0] A_OR   = 4'b0011;
    localparam logic [3:0] A_XOR  = 4'b0100;
    localparam logic [3:0] A_SLT  = 4'b0101;
    localparam logic [3:0] A_SLTU = 4'b0110;
    localparam logic [3:0] A_SLL  = 4'b0111;
    localparam logic [3:0] A_SRL  = 4'b1000;
    localparam logic [3:0] A_SRA  = 4'b1001;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int K_FETCH = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
    logic Illegal;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n, funct7b5, Zero, MemReady;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, MemTimeout;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    mc_control_fsm #(.WAIT_LIMIT(LIMIT), .WAIT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl),
`ifdef MC_ILLEGAL_TRAP_EN
        .Illegal(Illegal),
`endif
        .MemTimeout(MemTimeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // expected values and which select fields are defined for the current cycle
    logic       e_pcw, e_adr, e_mw, e_irw, e_rw, e_to, e_ill;
    logic [1:0] e_rs, e_sa, e_sb;
    logic [3:0] e_alu;
    bit         c_adr, c_rs, c_sa, c_sb, c_alu;
    bit         to_flag;
    logic [6:0] n_op;
    logic [2:0] n_f3;
    logic       n_f7;

    function automatic void imm_ref(input logic [6:0] o, output logic [2:0] v, output bit care);
        care = 1'b1;
        case (o)
            OP_LOAD, OP_OPIMM, OP_JALR: v = 3'b000;
            OP_STORE:                   v = 3'b001;
            OP_BRANCH:                  v = 3'b010;
            OP_LUI, OP_AUIPC:           v = 3'b011;
            OP_JAL:                     v = 3'b100;
            default: begin v = 3'b000; care = 1'b0; end
        endcase
    endfunction

    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input bit reg_form);
        case (f3)
            3'd0: return (reg_form && f7) ? A_SUB : A_ADD;
            3'd1: return A_SLL;
            3'd2: return A_SLT;
            3'd3: return A_SLTU;
            3'd4: return A_XOR;
            3'd5: return f7 ? A_SRA : A_SRL;
            3'd6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    task automatic exp_base();
        e_pcw = 1'b0; e_adr = 1'b0; e_mw = 1'b0; e_irw = 1'b0; e_rw = 1'b0;
        e_rs = 2'b00; e_sa = 2'b00; e_sb = 2'b00; e_alu = A_ADD;
        c_adr = 1'b0; c_rs = 1'b0; c_sa = 1'b0; c_sb = 1'b0; c_alu = 1'b1;
        e_to = to_flag; e_ill = 1'b0;
    endtask

    task automatic exp_fetch_sel();
        c_adr = 1'b1; c_sa = 1'b1; c_sb = 1'b1; c_rs = 1'b1;
        e_adr = 1'b0; e_sa = 2'b00; e_sb = 2'b10; e_rs = 2'b10;
    endtask

    task automatic compare(input string tag);
        logic [18:0] obs, expv, msk;
        logic [2:0]  e_imm;
        bit          c_imm;
        #1;
        imm_ref(op, e_imm, c_imm);
        obs  = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, MemTimeout};
        expv = {e_pcw, e_adr, e_mw, e_irw, e_rw, e_rs, e_sa, e_sb, e_imm, e_alu, e_to};
        msk  = {1'b1, c_adr, 3'b111, {2{c_rs}}, {2{c_sa}}, {2{c_sb}}, {3{c_imm}}, {4{c_alu}}, 1'b1};
        n_cmp++;
        assert ((obs & msk) === (expv & msk)) else begin
            n_bad++;
            $error("FAIL %s: observed %05h required %05h (mask %05h)", tag, obs & msk, expv & msk, msk);
        end
`ifdef MC_ILLEGAL_TRAP_EN
        n_cmp++;
        assert (Illegal === e_ill) else begin
            n_bad++;
            $error("FAIL %s/Illegal: observed %b required %b", tag, Illegal, e_ill);
        end
`endif
    endtask

    task automatic next_cycle();
        @(negedge clk);
        reset_n = 1'b1;
        op = n_op; funct3 = n_f3; funct7b5 = n_f7;
    endtask

    task automatic begin_plain();
        next_cycle();
        MemReady = 1'($urandom_range(0, 1));
        Zero     = 1'($urandom_range(0, 1));
        exp_base();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; MemReady = 1'b1; to_flag = 1'b0;
        exp_base(); exp_fetch_sel();
        compare("reset");
        @(negedge clk);
        compare("reset_hold");
    endtask

    task automatic illegal_phase(input string tag);
        begin_plain();
        e_ill = TRAP;
        compare(tag);
        if (TRAP) begin
            repeat (2) begin
                begin_plain();
                MemReady = 1'b1;
                e_ill = 1'b1;
                compare({tag, "_halt"});
            end
            do_reset();
        end
    endtask

    // One memory access: 'lows' not-ready cycles before MemReady, or a timeout
    task automatic mem_phase(input int kind, input int lows, input string tag, output bit ok);
        bit tmo;
        ok = 1'b1;
        for (int i = 0; i <= lows; i++) begin
            next_cycle();
            MemReady = (i == lows);
            Zero     = 1'($urandom_range(0, 1));
            tmo      = !MemReady && (i == LIMIT - 1);
            exp_base();
            c_adr = 1'b1;
            if (kind == K_FETCH) begin
                exp_fetch_sel();
                e_irw = MemReady && !tmo;
                e_pcw = MemReady && !tmo;
            end else begin
                e_adr = 1'b1;
                if (kind == K_READ) begin c_rs = 1'b1; e_rs = 2'b00; end
                else e_mw = !tmo;
            end
            compare(tag);
            if (tmo) begin
                to_flag = 1'b1;
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic cyc_sel(input string tag, input logic [1:0] sa, input logic [1:0] sb);
        begin_plain();
        c_sa = 1'b1; c_sb = 1'b1; e_sa = sa; e_sb = sb;
        compare(tag);
    endtask

    task automatic cyc_aluwb();
        begin_plain();
        c_rs = 1'b1; e_rs = 2'b00; e_rw = 1'b1;
        compare("aluwb");
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int flows, input int mlows, input logic z);
        bit   ok;
        logic taken;
        bit   bad_br;
        n_op = o; n_f3 = f3; n_f7 = f7;
        mem_phase(K_FETCH, flows, "fetch", ok);
        if (!ok) begin illegal_phase("tmo_fetch"); return; end
        cyc_sel("decode", 2'b01, 2'b01);
        case (o)
            OP_LOAD, OP_STORE: begin
                cyc_sel("memadr", 2'b10, 2'b01);
                mem_phase((o == OP_LOAD) ? K_READ : K_WRITE, mlows,
                          (o == OP_LOAD) ? "memread" : "memwrite", ok);
                if (!ok) begin illegal_phase("tmo_mem"); return; end
                if (o == OP_LOAD) begin
                    begin_plain();
                    c_rs = 1'b1; e_rs = 2'b01; e_rw = 1'b1;
                    compare("memwb");
                end
            end
            OP_RTYPE: begin
                begin_plain();
                c_sa = 1'b1; c_sb = 1'b1; e_sa = 2'b10; e_sb = 2'b00;
                e_alu = alu_ref(f3, f7, 1'b1);
                compare("execr");
                cyc_aluwb();
            end
            OP_OPIMM: begin
                begin_plain();
                c_sb = 1'b1; e_sb = 2'b01;
                e_alu = alu_ref(f3, f7, 1'b0);
                compare("execi");
                cyc_aluwb();
            end
            OP_BRANCH: begin
                begin_plain();
                Zero = z;
                c_sa = 1'b1; c_sb = 1'b1; c_rs = 1'b1;
                e_sa = 2'b10; e_sb = 2'b00; e_rs = 2'b00;
                bad_br = 1'b0;
                case (f3)
                    3'b000: begin e_alu = A_SUB;  taken = z;  end
                    3'b001: begin e_alu = A_SUB;  taken = !z; end
                    3'b100: begin e_alu = A_SLT;  taken = !z; end
                    3'b101: begin e_alu = A_SLT;  taken = z;  end
                    3'b110: begin e_alu = A_SLTU; taken = !z; end
                    3'b111: begin e_alu = A_SLTU; taken = z;  end
                    default: begin c_alu = 1'b0; taken = 1'b0; bad_br = 1'b1; end
                endcase
                e_pcw = taken;
                compare("branch");
                if (bad_br) illegal_phase("br_illegal");
            end
            OP_JAL, OP_JALR: begin
                if (o == OP_JALR) cyc_sel("jalradr", 2'b10, 2'b01);
                begin_plain();
                c_sa = 1'b1; c_sb = 1'b1; c_rs = 1'b1;
                e_sa = 2'b01; e_sb = 2'b10; e_rs = 2'b00; e_pcw = 1'b1;
                compare("jal");
                cyc_aluwb();
            end
            OP_LUI: begin
                cyc_sel("lui", 2'b11, 2'b01);
                cyc_aluwb();
            end
            OP_AUIPC: begin
                cyc_sel("auipc", 2'b01, 2'b01);
                cyc_aluwb();
            end
            default: illegal_phase("illegal_op");
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [6:0]  o;
        int          fl, ml;
        reset_n = 1'b0; MemReady = 1'b0; Zero = 1'b0; to_flag = 1'b0;
        n_op = OP_RTYPE; n_f3 = 3'b000; n_f7 = 1'b0;
        op = n_op; funct3 = n_f3; funct7b5 = n_f7;
        do_reset();

        // add with a 3-cycle fetch wait, then sub, srai
        run_instr(OP_RTYPE, 3'b000, 1'b0, 3, 0, 1'b0);
        run_instr(OP_RTYPE, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr(OP_OPIMM, 3'b101, 1'b1, 0, 0, 1'b0);
        run_instr(OP_OPIMM, 3'b000, 1'b1, 1, 0, 1'b0);
        // blt / bge with Zero = 0, beq taken, unsupported branch funct3
        run_instr(OP_BRANCH, 3'b100, 1'b0, 0, 0, 1'b0);
        run_instr(OP_BRANCH, 3'b101, 1'b0, 0, 0, 1'b0);
        run_instr(OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b1);
        run_instr(OP_BRANCH, 3'b010, 1'b0, 0, 0, 1'b0);
        // loads/stores with waits, jumps, upper immediates, bad opcode
        run_instr(OP_LOAD, 3'b010, 1'b0, 0, 2, 1'b0);
        run_instr(OP_STORE, 3'b010, 1'b0, 2, 4, 1'b0);
        run_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_JALR, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_LUI, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_AUIPC, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);

        // lw whose MEMREAD never completes
        run_instr(OP_LOAD, 3'b010, 1'b0, 0, LIMIT, 1'b0);
        run_instr(OP_RTYPE, 3'b111, 1'b0, 0, 0, 1'b0);

        // reset pulsed while a store is holding MemWrite
        do_reset();
        n_op = OP_STORE; n_f3 = 3'b010; n_f7 = 1'b0;
        mem_phase(K_FETCH, 0, "st_fetch", ok);
        cyc_sel("st_decode", 2'b01, 2'b01);
        cyc_sel("st_memadr", 2'b10, 2'b01);
        next_cycle();
        MemReady = 1'b0;
        exp_base(); c_adr = 1'b1; e_adr = 1'b1; e_mw = 1'b1;
        compare("st_memwrite");
        #2;
        reset_n = 1'b0;
        to_flag = 1'b0;
        exp_base(); exp_fetch_sel();
        compare("async_reset");
        do_reset();

        // randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: o = OP_LOAD;
                1: o = OP_STORE;
                2: o = OP_RTYPE;
                3: o = OP_OPIMM;
                4: o = OP_BRANCH;
                5: o = OP_JAL;
                6: o = OP_JALR;
                7: o = OP_LUI;
                8: o = OP_AUIPC;
                default: o = 7'($urandom);
            endcase
            fl = ($urandom_range(0, 15) == 0) ? LIMIT : $urandom_range(0, 3);
            ml = ($urandom_range(0, 15) == 0) ? LIMIT : $urandom_range(0, 3);
            run_instr(o, 3'($urandom), 1'($urandom), fl, ml, 1'($urandom));
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit of the multi-cycle RV32I core.
- Decodes the latched instruction fields and sequences fetch, decode, execute, memory and writeback states.
- Drives the datapath mux selects and write enables, plus ALUControl for the ALU, using the ALU_* encodings from alucontrol.v.
- Consumes the ALU Zero flag to resolve branches.

Parameters:
- WAIT_LIMIT, 0, max cycles a memory state waits for MemReady; 0 = wait forever.
- WAIT_W, 8, width of the wait counter; requires WAIT_LIMIT < 2^WAIT_W.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  instruction opcode, from the instruction register.
- funct3  in  3  instruction bits 14:12.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory access-complete handshake.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  enables the instruction register and the OldPC latch.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = MemData, 10 = ALUResult.
- ALUSrcA  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  SrcB select: 00 = rs2, 01 = Imm, 10 = constant 4.
- ImmSrc  out  3  immediate format: I = 000, S = 001, B = 010, U = 011, J = 100.
- ALUControl  out  4  ALU operation code.
- MemTimeout  out  1  sticky flag: a memory wait expired.

Behaviour:
- State register is reset asynchronously to FETCH while reset_n = 0. All outputs are combinational from state, fields and inputs (Moore plus MemReady/Zero gating).
- While reset_n = 0, every write enable (PCWrite, MemWrite, IRWrite, RegWrite) is forced to 0, and MemTimeout = 0.
- ImmSrc is decoded from op alone: load/OP-IMM/JALR = I, store = S, branch = B, LUI/AUIPC = U, JAL = J.
- Every state not listed below drives ALUControl = ADD.
- FETCH: AdrSrc = 0; ALUSrcA = 00; ALUSrcB = 10; ResultSrc = 10; IRWrite = PCWrite = MemReady. Stays in FETCH until MemReady = 1, then goes to DECODE.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ADD (precomputes the branch target). Next state by op:
  - load/store -> MEMADR
  - R-type -> EXECR
  - OP-IMM -> EXECI
  - branch -> BRANCH
  - JAL -> JAL
  - JALR -> JALRADR
  - LUI -> LUI
  - AUIPC -> AUIPC
  - any other op -> ILLEGAL
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ADD. Next: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. Waits for MemReady, then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, then FETCH.
- MEMWRITE: AdrSrc = 1, MemWrite = 1 held until MemReady, then FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00. ALUControl by funct3:
  - 000: SUB if funct7b5 = 1, else ADD
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR
  - 101: SRA if funct7b5 = 1, else SRL
  - 110: OR; 111: AND
  - next state ALUWB.
- EXECI: ALUSrcB = 01, same ALUControl table except funct3 = 000 is always ADD; next state ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, then FETCH.
- BRANCH: ALUSrcA = 10, ALUSrcB = 00, ResultSrc = 00, then FETCH. Per funct3:
  - BEQ: SUB, taken = Zero
  - BNE: SUB, taken = !Zero
  - BLT: SLT, taken = !Zero
  - BGE: SLT, taken = Zero
  - BLTU: SLTU, taken = !Zero
  - BGEU: SLTU, taken = Zero
  - PCWrite = taken.
  - funct3 = 010/011 -> ILLEGAL, PCWrite = 0.
- JALRADR: ALUSrcA = 10, ALUSrcB = 01, ADD, then JAL.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 00, PCWrite = 1 (PC <- ALUOut target), then ALUWB (rd <- OldPC+4).
- LUI: ALUSrcA = 11, ALUSrcB = 01, then ALUWB.
- AUIPC: ALUSrcA = 01, ALUSrcB = 01, then ALUWB.
- Wait counter (only when WAIT_LIMIT > 0):
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE; increments each cycle MemReady = 0.
  - On reaching WAIT_LIMIT: MemTimeout is set (sticky until reset) and the FSM goes to ILLEGAL with no enables asserted.
- MemReady must be asserted for one cycle per access. If MemReady and the limit coincide, MemReady wins.
- ILLEGAL: see the optional feature below.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL is terminal (halt); all enables are 0 and output Illegal (1 bit, reset 0) = 1 until reset.
- Undefined: ILLEGAL acts as a one-cycle NOP; no enables asserted, next state FETCH; no Illegal port.

Test Plan:
- reset_n pulsed low mid-MEMWRITE -> MemWrite drops asynchronously, state = FETCH, all enables 0 until reset_n high.
- FETCH with MemReady low 3 cycles, then high -> IRWrite = PCWrite = 1 only in the 4th cycle; DECODE follows.
- add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0) -> FETCH, DECODE, EXECR (ALUControl = ADD), ALUWB with RegWrite = 1: 4 cycles total.
- sub variant (funct7b5 = 1) gives SUB in EXECR; srai (op 0010011, funct3 101, funct7b5 = 1) gives SRA in EXECI.
- blt with Zero = 0 -> PCWrite = 1 in BRANCH (ALUControl = SLT); bge with Zero = 0 -> PCWrite = 0.
- lw with WAIT_LIMIT = 5 and MemReady stuck low -> MemTimeout = 1 after 5 MEMREAD cycles. With MC_ILLEGAL_TRAP_EN, Illegal = 1 and the FSM halts; without it, the FSM returns to FETCH.
